// File: rtl/brstat_pkg.sv
// Shared types and helpers for the branch statistics counter.
//   CNT_W_DEF    : default counter / snapshot width
//   brstat_inc_t : per-cycle increment of one counter (0..2)
//   pair_inc()   : increment contributed by the two retire slots
package brstat_pkg;

    localparam int CNT_W_DEF = 32;

    typedef logic [1:0] brstat_inc_t;

    // Each slot contributes only when its valid is high. For the total count,
    // pass 1'b1 as the qualifier.
    function automatic brstat_inc_t pair_inc(input logic v0, input logic q0,
                                             input logic v1, input logic q1);
        return brstat_inc_t'({1'b0, v0 & q0}) + brstat_inc_t'({1'b0, v1 & q1});
    endfunction

endpackage

// File: rtl/brstat_sat_cnt.sv
// One saturating accumulator: cnt += inc (0..2), sticking at all-ones.
//   clk_core, rstn : clock, async active-low reset
//   inc            : increment for this cycle
//   clr            : synchronous clear, wins over en
//   en             : count enable
//   cnt            : current value
module brstat_sat_cnt
    import brstat_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk_core,
    input  logic         rstn,
    input  brstat_inc_t  inc,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // One extra bit holds the carry; a set carry means the sum passed the max.
    logic [W:0] sum;
    assign sum = {1'b0, cnt} + {{(W-1){1'b0}}, inc};

    always_ff @(posedge clk_core or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= sum[W] ? {W{1'b1}} : sum[W-1:0];
    end

endmodule

// File: rtl/branch_stat_counter.sv
// Branch statistics: live saturating counters for total, taken and mispredicted
// branches from two retire slots, plus snapshot registers refreshed every
// SNAP_PERIOD cycles so a multiplexed display never sees a torn value.
//   clk_core, rstn                : clock, async active-low reset
//   i_i{0,1}_br_valid/taken/mispred : retire slot branch info
//   i_clear                       : async switch level, rising edge clears all
//   i_freeze                      : hold live counters while high
//   o_branches/o_taken/o_mispred  : snapshot values
//   o_snap_stb                    : high in the first cycle a new snapshot is visible
module branch_stat_counter
    import brstat_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SNAP_PERIOD = 1000000
) (
    input  logic             clk_core,
    input  logic             rstn,
    input  logic             i_i0_br_valid,
    input  logic             i_i0_br_taken,
    input  logic             i_i0_br_mispred,
    input  logic             i_i1_br_valid,
    input  logic             i_i1_br_taken,
    input  logic             i_i1_br_mispred,
    input  logic             i_clear,
    input  logic             i_freeze,
    output logic [CNT_W-1:0] o_branches,
    output logic [CNT_W-1:0] o_taken,
    output logic [CNT_W-1:0] o_mispred,
    output logic             o_snap_stb
);

    localparam int            TW   = (SNAP_PERIOD > 2) ? $clog2(SNAP_PERIOD) : 1;
    localparam logic [TW-1:0] LAST = TW'(SNAP_PERIOD - 1);

    // Clear switch: 2-flop synchronizer, then rising-edge detect.
    logic [1:0] clr_sync;
    logic       clr_q;
    logic       clr_p;

    always_ff @(posedge clk_core or negedge rstn) begin
        if (!rstn) begin
            clr_sync <= '0;
            clr_q    <= 1'b0;
        end else begin
            clr_sync <= {clr_sync[0], i_clear};
            clr_q    <= clr_sync[1];
        end
    end

    assign clr_p = clr_sync[1] & ~clr_q;

    // Live counters: index 0 total, 1 taken, 2 mispredicted.
    brstat_inc_t [2:0]            incs;
    logic        [2:0][CNT_W-1:0] live;
    logic                         cnt_en;

    assign incs[0] = pair_inc(i_i0_br_valid, 1'b1, i_i1_br_valid, 1'b1);
    assign incs[1] = pair_inc(i_i0_br_valid, i_i0_br_taken, i_i1_br_valid, i_i1_br_taken);
    assign incs[2] = pair_inc(i_i0_br_valid, i_i0_br_mispred, i_i1_br_valid, i_i1_br_mispred);
    assign cnt_en  = ~i_freeze;

    // clr_p takes priority inside the counter, so events in the clear cycle drop.
    for (genvar g = 0; g < 3; g++) begin : g_cnt
        brstat_sat_cnt #(.W(CNT_W)) u_cnt (
            .clk_core (clk_core),
            .rstn     (rstn),
            .inc      (incs[g]),
            .clr      (clr_p),
            .en       (cnt_en),
            .cnt      (live[g])
        );
    end

    // Snapshot timer and registers. The snapshot loads the live value as it
    // stands before this cycle's increments; those show up one period later.
    logic [TW-1:0]           timer;
    logic [2:0][CNT_W-1:0]   snap;
    logic                    snap_pt;

    assign snap_pt = (timer == LAST);

    always_ff @(posedge clk_core or negedge rstn) begin
        if (!rstn) begin
            timer      <= '0;
            snap       <= '0;
            o_snap_stb <= 1'b0;
        end else if (clr_p) begin
            // Clear beats a coincident snapshot and restarts the period.
            timer      <= '0;
            snap       <= '0;
            o_snap_stb <= 1'b1;
        end else if (snap_pt) begin
            timer      <= '0;
            snap       <= live;
            o_snap_stb <= 1'b1;
        end else begin
            timer      <= timer + TW'(1);
            o_snap_stb <= 1'b0;
        end
    end

    assign o_branches = snap[0];
    assign o_taken    = snap[1];
    assign o_mispred  = snap[2];

endmodule

// File: tb/tb_branch_stat_counter.sv
module tb_branch_stat_counter;

    localparam int  P     = 8;
    localparam longint MAX32 = 64'hFFFF_FFFF;
    localparam longint MAX4  = 15;

    logic        clk_core, rstn;
    logic        v0, t0, m0, v1, t1, m1, clr, frz;
    logic [31:0] ob, ot, om;
    logic [3:0]  sb, st, sm;
    logic        stb, stb_s;

    int checks   = 0;
    int failures = 0;

    branch_stat_counter #(.CNT_W(32), .SNAP_PERIOD(P)) dut (
        .clk_core(clk_core), .rstn(rstn),
        .i_i0_br_valid(v0), .i_i0_br_taken(t0), .i_i0_br_mispred(m0),
        .i_i1_br_valid(v1), .i_i1_br_taken(t1), .i_i1_br_mispred(m1),
        .i_clear(clr), .i_freeze(frz),
        .o_branches(ob), .o_taken(ot), .o_mispred(om), .o_snap_stb(stb)
    );

    branch_stat_counter #(.CNT_W(4), .SNAP_PERIOD(P)) dut_s (
        .clk_core(clk_core), .rstn(rstn),
        .i_i0_br_valid(v0), .i_i0_br_taken(t0), .i_i0_br_mispred(m0),
        .i_i1_br_valid(v1), .i_i1_br_taken(t1), .i_i1_br_mispred(m1),
        .i_clear(clr), .i_freeze(frz),
        .o_branches(sb), .o_taken(st), .o_mispred(sm), .o_snap_stb(stb_s)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    typedef struct {
        bit v0, t0, m0, v1, t1, m1, frz, clr;
        int n;
        bit chk, stb;
        int b, t, m, sb, st, sm;
    } vec_t;

    typedef struct {
        logic        stb;
        logic [31:0] b, t, m;
        logic [3:0]  sb, st, sm;
    } exp_t;

    exp_t   q[$];
    vec_t   tbl[16];

    // Reference model state
    longint lv[3], ls[3], sv[3], ss[3];
    int     tmr;
    bit     ms0, ms1, mpr, mstb;

    function automatic longint sat(longint v, longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin lv[k] = 0; ls[k] = 0; sv[k] = 0; ss[k] = 0; end
        tmr = 0; ms0 = 0; ms1 = 0; mpr = 0; mstb = 0;
    endtask

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic string outs();
        return $sformatf("got stb=%0b/%0b b=%0d t=%0d m=%0d sat=%0d/%0d/%0d",
                         stb, stb_s, ob, ot, om, sb, st, sm);
    endfunction

    // Drive one cycle, predict the post-edge outputs, then compare.
    task automatic step(input vec_t s);
        exp_t e;
        bit   cp;
        int   inc[3];
        v0 = s.v0; t0 = s.t0; m0 = s.m0;
        v1 = s.v1; t1 = s.t1; m1 = s.m1;
        frz = s.frz; clr = s.clr;
        cp  = ms1 & ~mpr;
        mpr = ms1; ms1 = ms0; ms0 = s.clr;
        inc[0] = int'(s.v0) + int'(s.v1);
        inc[1] = int'(s.v0 & s.t0) + int'(s.v1 & s.t1);
        inc[2] = int'(s.v0 & s.m0) + int'(s.v1 & s.m1);
        if (cp) begin
            for (int k = 0; k < 3; k++) begin lv[k] = 0; ls[k] = 0; sv[k] = 0; ss[k] = 0; end
            tmr = 0; mstb = 1;
        end else begin
            if (tmr == P - 1) begin
                for (int k = 0; k < 3; k++) begin sv[k] = lv[k]; ss[k] = ls[k]; end
                tmr = 0; mstb = 1;
            end else begin
                tmr++; mstb = 0;
            end
            if (!s.frz)
                for (int k = 0; k < 3; k++) begin
                    lv[k] = sat(lv[k] + inc[k], MAX32);
                    ls[k] = sat(ls[k] + inc[k], MAX4);
                end
        end
        e.stb = mstb;
        e.b  = 32'(sv[0]); e.t  = 32'(sv[1]); e.m  = 32'(sv[2]);
        e.sb = 4'(ss[0]);  e.st = 4'(ss[1]);  e.sm = 4'(ss[2]);
        q.push_back(e);
        @(posedge clk_core);
        @(negedge clk_core);
        e = q.pop_front();
        check("cycle", stb === e.stb && stb_s === e.stb && ob === e.b && ot === e.t &&
              om === e.m && sb === e.sb && st === e.st && sm === e.sm,
              $sformatf("%s exp stb=%0b b=%0d t=%0d m=%0d sat=%0d/%0d/%0d",
                        outs(), e.stb, e.b, e.t, e.m, e.sb, e.st, e.sm));
    endtask

    initial begin
        vec_t d;
        //          v0 t0 m0 v1 t1 m1 fz cl  n  chk stb  b   t  m  sb st sm
        tbl[0]  = '{0, 1, 1, 0, 1, 1, 0, 0, 16, 1, 1,  0,  0, 0,  0, 0, 0}; // unqualified
        tbl[1]  = '{1, 1, 0, 1, 0, 0, 0, 0, 10, 0, 0,  0,  0, 0,  0, 0, 0}; // dual, i0 taken
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0,  6, 1, 1, 20, 10, 0, 15,10, 0};
        tbl[3]  = '{1, 1, 0, 1, 1, 0, 0, 0, 10, 0, 0,  0,  0, 0,  0, 0, 0}; // both taken
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,  6, 1, 1, 40, 30, 0, 15,15, 0};
        tbl[5]  = '{1, 1, 1, 1, 1, 1, 1, 0,  8, 1, 1, 40, 30, 0, 15,15, 0}; // frozen
        tbl[6]  = '{1, 0, 1, 1, 0, 1, 0, 0,  2, 0, 0,  0,  0, 0,  0, 0, 0}; // mispred
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0,  6, 1, 1, 44, 30, 4, 15,15, 4};
        tbl[8]  = '{1, 1, 0, 1, 0, 0, 0, 1,  3, 1, 1,  0,  0, 0,  0, 0, 0}; // clear rises
        tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 1,  5, 0, 0,  0,  0, 0,  0, 0, 0}; // clear held
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 1,  3, 1, 1,  5,  0, 0,  5, 0, 0};
        tbl[11] = '{1, 1, 0, 1, 0, 0, 0, 0,  3, 0, 0,  0,  0, 0,  0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0,  0,  0, 0,  0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 1,  3, 1, 1,  0,  0, 0,  0, 0, 0}; // clear on snapshot
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 1,  8, 1, 1,  0,  0, 0,  0, 0, 0}; // restarted period
        tbl[15] = '{1, 1, 0, 1, 0, 1, 0, 0, 10, 1, 0, 14,  7, 7, 14, 7, 7};
        d       = '{1, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0,  0,  0, 0,  0, 0, 0};

        rstn = 1'b0;
        {v0, t0, m0, v1, t1, m1, clr, frz} = '0;
        model_reset();
        #1;
        check("reset", ob === 0 && ot === 0 && om === 0 && stb === 0 &&
              sb === 0 && st === 0 && sm === 0 && stb_s === 0, outs());
        repeat (2) @(negedge clk_core);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < tbl[i].n; c++) step(tbl[i]);
            if (tbl[i].chk)
                check($sformatf("vec%0d", i),
                      stb === tbl[i].stb && ob === 32'(tbl[i].b) && ot === 32'(tbl[i].t) &&
                      om === 32'(tbl[i].m) && sb === 4'(tbl[i].sb) && st === 4'(tbl[i].st) &&
                      sm === 4'(tbl[i].sm),
                      $sformatf("%s exp stb=%0b b=%0d t=%0d m=%0d sat=%0d/%0d/%0d", outs(),
                                tbl[i].stb, tbl[i].b, tbl[i].t, tbl[i].m,
                                tbl[i].sb, tbl[i].st, tbl[i].sm));
        end

        // Asynchronous reset in mid-period with nonzero snapshots.
        #2 rstn = 1'b0;
        #1;
        check("midrun_reset", ob === 0 && ot === 0 && om === 0 && stb === 0 &&
              sb === 0 && st === 0 && sm === 0, outs());
        model_reset();
        q.delete();
        @(negedge clk_core);
        rstn = 1'b1;
        for (int i = 0; i < P; i++) begin
            step(d);
            if (i == P - 2) check("first_snap_early", stb === 1'b0, outs());
        end
        check("first_snap", stb === 1'b1 && ob === 32'd14 && ot === 32'd0 && om === 32'd0,
              $sformatf("%s exp stb=1 b=14 t=0 m=0", outs()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_stat_counter.md
# branch_stat_counter

Counts retired branches, taken branches and mispredictions from the core's two retire slots (i0/i1) in saturating counters. It publishes periodic stable snapshots to the seven-segment/LED display logic in the Nexys A7 top level, which reads `branches_counter` and `branches_taken_counter`. Snapshots update only at a fixed refresh interval, so a multiplexed display never shows a value torn mid-update. A board switch clears all counters.

## Interface
- `CNT_W`, 32: width of every counter and snapshot output.
- `SNAP_PERIOD`, 1000000: clk_core cycles between snapshots; legal range is 2 to 2^24.
- `clk_core` input 1: core clock; all logic is on this edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `i_i0_br_valid` input 1: slot 0 retired a branch this cycle.
- `i_i0_br_taken` input 1: slot 0 branch taken; qualified by valid.
- `i_i0_br_mispred` input 1: slot 0 branch mispredicted; qualified by valid.
- `i_i1_br_valid`, `i_i1_br_taken`, `i_i1_br_mispred` input 1 each: the same three signals for slot 1.
- `i_clear` input 1: asynchronous level from a board switch; a rising edge clears all counters.
- `i_freeze` input 1: synchronous; while high, no events are counted.
- `o_branches` output CNT_W: snapshot of the total branch count.
- `o_taken` output CNT_W: snapshot of the taken count.
- `o_mispred` output CNT_W: snapshot of the mispredict count.
- `o_snap_stb` output 1: one-cycle pulse in the cycle a new snapshot becomes visible.

## Operation
- **Increments.** Per cycle, each counter's increment is 0, 1 or 2.
  - Total: i0_valid + i1_valid.
  - Taken: (i0_valid & i0_taken) + (i1_valid & i1_taken).
  - Mispred: (i0_valid & i0_mispred) + (i1_valid & i1_mispred).
  - Taken and mispred bits are ignored when their slot's valid is low. This guarantees taken ≤ total and mispred ≤ total.
- **Saturation.** Each counter saturates at 2^CNT_W−1 and never wraps. If value + inc would exceed the maximum, the result is the maximum.
- **Freeze.** With `i_freeze`=1, live counters hold. The snapshot timer keeps running and snapshots keep firing.
- **Clear path.** `i_clear` passes through a 2-flop synchronizer and then a rising-edge detector, producing an internal `clr_p` pulse.
- **Clear action.** On `clr_p`:
  - live counters, snapshot registers and the period timer all go to 0 on the next edge;
  - `o_snap_stb` pulses in that cycle;
  - events in the `clr_p` cycle are dropped.
  - Holding `i_clear` high does not re-clear; counting resumes.
- **Snapshot timer.** A free-running timer counts 0 to SNAP_PERIOD−1 and wraps. When it equals SNAP_PERIOD−1, the snapshot registers load the current live register values, excluding that cycle's increments. Those increments appear in the next snapshot.
- **Clear/snapshot collision.** If `clr_p` and the snapshot point coincide, clear wins.

## Timing
- **Reset.** All live counters, snapshots, `o_branches`/`o_taken`/`o_mispred` = 0; `o_snap_stb` = 0; timer = 0; synchronizer flops = 0.
- **Live counter latency.** An event sampled at edge N is in the live counter after edge N.
- **Snapshot latency.** Outputs change only at edges where the timer was SNAP_PERIOD−1, or on clear. `o_snap_stb` is high during the cycle after that edge, which is the first cycle the new values are valid.
- **First snapshot.** After reset release, the first snapshot edge is edge SNAP_PERIOD, counting from the first active edge as edge 1.
- **Clear latency.** From an `i_clear` rising edge to outputs = 0 is 3 edges: two synchronizer stages, then the clear.
- **Registered outputs.** All outputs are registered; there are no combinational input-to-output paths.
- **Reset mid-run.** Assertion returns all state to the reset values immediately.

## Structure
- **Package `brstat_pkg`:**
  - `CNT_W` default;
  - `brstat_inc_t` (2-bit increment);
  - a function computing the slot-pair increment.
- **Sub-module `brstat_sat_cnt`:** one CNT_W saturating accumulator with inputs inc (0–2), clr, en. It is instantiated three times.
- **Top-level integration.** The Nexys top maps `o_branches[15:0]` and `o_taken[15:0]` onto its display digits.

## Test plan
- **Dual-slot counting.** SNAP_PERIOD=8. Drive 10 cycles with both slots valid, i0 taken, i1 not taken, no mispredicts. Then snapshot → o_branches=20, o_taken=10, o_mispred=0, with one `o_snap_stb` pulse per 8 cycles.
- **Unqualified bits ignored.** Assert taken=1, mispred=1 with valid=0 for 16 cycles → all snapshots stay 0.
- **Saturation.** CNT_W=4. Drive 10 cycles of dual valid+taken → o_branches=15, o_taken=15, with no wrap to 0–3.
- **Clear.** Raise `i_clear` after counts of 37/12/3 → 0/0/0 and `o_snap_stb` 3 edges later. Keep `i_clear` high for 20 cycles with 5 events → next snapshot shows 5 (not re-cleared).
- **Clear/snapshot collision.** Make `clr_p` coincide with timer=SNAP_PERIOD−1 → outputs 0 and the timer restarts at 0.
- **Freeze.** `i_freeze`=1 for 8 cycles of dual events between snapshots → counts unchanged, `o_snap_stb` still pulses on schedule. Async reset mid-period → all outputs 0 immediately.
